// File: rtl/pipe_stage_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid_reg
//   Inter-stage pipeline register carrying one packed payload bus through a
//   valid/ready handshake. A two-entry (main + skid) buffer lets in_ready come
//   straight from a flop, so the upstream ready path never sees out_ready.
//   Adds per-beat kill (bubble insertion), whole-stage flush, an occupancy
//   output and a saturating stall counter.
//
// Parameters
//   DATA_W      payload width in bits
//   RESET_DATA  value data_out takes in reset (pc / NOP encodings per stage)
//   CNT_W       stall counter width
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   in_valid   upstream beat present
//   in_kill    accepted beat is dropped instead of stored
//   in_ready   stage can take a beat (registered, = !skid valid)
//   data_in    upstream payload
//   out_valid  data_out holds a live beat
//   out_ready  downstream accepts this cycle
//   data_out   payload of the head (main) entry
//   flush      discard all held beats
//   clr_stats  synchronous clear of stall_cnt
//   occupancy  live entries, 0..2
//   stall_cnt  cycles with out_valid=1 and out_ready=0, saturating
// ---------------------------------------------------------------------------
module pipe_stage_skid_reg #(
   parameter int                DATA_W     = 64,
   parameter logic [DATA_W-1:0] RESET_DATA = '0,
   parameter int                CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              in_kill,
   output logic              in_ready,
   input  logic [DATA_W-1:0] data_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] data_out,
   input  logic              flush,
   input  logic              clr_stats,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              r_main_v, r_skid_v;
   logic [DATA_W-1:0] r_main_d, r_skid_d;
   logic [1:0]        r_occ;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic              w_acc, w_keep, w_pop;
   logic              w_main_v_nxt, w_skid_v_nxt;
   logic [DATA_W-1:0] w_main_d_nxt, w_skid_d_nxt;

   assign in_ready  = !r_skid_v;
   assign out_valid = r_main_v;
   assign data_out  = r_main_d;
   assign occupancy = r_occ;
   assign stall_cnt = r_stall_cnt;

   assign w_acc  = in_valid & in_ready;
   assign w_keep = w_acc & !in_kill;
   assign w_pop  = r_main_v & out_ready;

   always_comb begin
      w_main_v_nxt = r_main_v;
      w_skid_v_nxt = r_skid_v;
      w_main_d_nxt = r_main_d;
      w_skid_d_nxt = r_skid_d;
      if (flush) begin
         // payload flops keep their contents; only the valids drop
         w_main_v_nxt = 1'b0;
         w_skid_v_nxt = 1'b0;
      end else if (r_skid_v && w_pop) begin
         // in_ready is low here, so no new beat can race the skid promote
         w_main_d_nxt = r_skid_d;
         w_main_v_nxt = 1'b1;
         w_skid_v_nxt = 1'b0;
      end else if (w_keep && (!r_main_v || w_pop)) begin
         w_main_d_nxt = data_in;
         w_main_v_nxt = 1'b1;
      end else if (w_keep) begin
         // main is held by a stalled downstream: park the beat in skid
         w_skid_d_nxt = data_in;
         w_skid_v_nxt = 1'b1;
      end else if (w_pop) begin
         w_main_v_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_main_v    <= 1'b0;
         r_skid_v    <= 1'b0;
         r_main_d    <= RESET_DATA;
         r_skid_d    <= '0;
         r_occ       <= 2'd0;
         r_stall_cnt <= '0;
      end else begin
         r_main_v <= w_main_v_nxt;
         r_skid_v <= w_skid_v_nxt;
         r_main_d <= w_main_d_nxt;
         r_skid_d <= w_skid_d_nxt;
         r_occ    <= {1'b0, w_main_v_nxt} + {1'b0, w_skid_v_nxt};
         if (clr_stats)
            r_stall_cnt <= '0;
         else if (r_main_v && !out_ready && r_stall_cnt != CNT_MAX)
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
   end

   // skid may only hold a beat while main is occupied
   a_skid_implies_main: assert property (@(posedge clk) disable iff (!rst)
      r_skid_v |-> r_main_v);

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid_reg
//   Directed bench. Two instances share all inputs: dut (CNT_W=16,
//   RESET_DATA=0x8000_0000) carries the handshake checks, dut3 (CNT_W=3,
//   RESET_DATA=0) shows counter saturation. Inputs change 1ns after the
//   rising edge and outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_kill, out_ready, flush, clr_stats;
   logic [63:0] data_in;

   logic        in_ready, out_valid;
   logic [63:0] data_out;
   logic [1:0]  occupancy;
   logic [15:0] stall_cnt;

   logic        in_ready3, out_valid3;
   logic [63:0] data_out3;
   logic [1:0]  occupancy3;
   logic [2:0]  stall_cnt3;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   pipe_stage_skid_reg #(.DATA_W(64), .RESET_DATA(64'h8000_0000), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_kill(in_kill),
      .in_ready(in_ready), .data_in(data_in), .out_valid(out_valid),
      .out_ready(out_ready), .data_out(data_out), .flush(flush),
      .clr_stats(clr_stats), .occupancy(occupancy), .stall_cnt(stall_cnt)
   );

   pipe_stage_skid_reg #(.DATA_W(64), .RESET_DATA(64'h0), .CNT_W(3)) dut3 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_kill(in_kill),
      .in_ready(in_ready3), .data_in(data_in), .out_valid(out_valid3),
      .out_ready(out_ready), .data_out(data_out3), .flush(flush),
      .clr_stats(clr_stats), .occupancy(occupancy3), .stall_cnt(stall_cnt3)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; in_valid = 0; in_kill = 0; out_ready = 0; flush = 0;
      clr_stats = 0; data_in = '0;
      #12;
      // reset state
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'd1);
      chk("rst_occ",       64'(occupancy), 64'd0);
      chk("rst_data_out",  data_out,       64'h8000_0000);
      chk("rst_stall",     64'(stall_cnt), 64'd0);
      chk("rst_data_out3", data_out3,      64'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      tick();
      chk("post_rst_occ", 64'(occupancy), 64'd0);

      // streaming, one beat per cycle
      out_ready = 1; in_valid = 1; data_in = 64'h11;
      tick(); chk("s1_data", data_out, 64'h11); chk("s1_occ", 64'(occupancy), 64'd1);
      data_in = 64'h22;
      tick(); chk("s2_data", data_out, 64'h22); chk("s2_occ", 64'(occupancy), 64'd1);
      data_in = 64'h33;
      tick(); chk("s3_data", data_out, 64'h33); chk("s3_vld", 64'(out_valid), 64'd1);
      in_valid = 0;
      tick(); chk("s_drain_vld", 64'(out_valid), 64'd0); chk("s_drain_occ", 64'(occupancy), 64'd0);

      // stall fills main then skid; third beat held upstream
      out_ready = 0; in_valid = 1; data_in = 64'hA1;
      tick(); chk("f1_occ", 64'(occupancy), 64'd1);
      data_in = 64'hA2;
      tick(); chk("f2_occ", 64'(occupancy), 64'd2); chk("f2_rdy", 64'(in_ready), 64'd0);
      data_in = 64'hA3;
      tick(); chk("f3_occ", 64'(occupancy), 64'd2);
      tick(); chk("f4_data", data_out, 64'hA1); chk("f4_rdy", 64'(in_ready), 64'd0);
      chk("f4_stall", 64'(stall_cnt), 64'd3);
      out_ready = 1;
      tick(); chk("d1_data", data_out, 64'hA2); chk("d1_occ", 64'(occupancy), 64'd1);
      chk("d1_rdy", 64'(in_ready), 64'd1);
      tick(); chk("d2_data", data_out, 64'hA3);
      in_valid = 0;
      tick(); chk("d3_vld", 64'(out_valid), 64'd0);
      chk("d3_stall", 64'(stall_cnt), 64'd3);

      // kill inserts a bubble
      in_valid = 1; in_kill = 1; data_in = 64'h55;
      chk("k1_rdy", 64'(in_ready), 64'd1);
      tick(); chk("k1_vld", 64'(out_valid), 64'd0); chk("k1_occ", 64'(occupancy), 64'd0);
      in_kill = 0; data_in = 64'h66;
      chk("k2_rdy", 64'(in_ready), 64'd1);
      tick(); chk("k2_vld", 64'(out_valid), 64'd1); chk("k2_data", data_out, 64'h66);
      in_valid = 0;
      tick(); chk("k3_vld", 64'(out_valid), 64'd0);

      // flush while full with a beat offered
      out_ready = 0; in_valid = 1; data_in = 64'hB1;
      tick();
      data_in = 64'hB2;
      tick(); chk("fl_pre_occ", 64'(occupancy), 64'd2);
      flush = 1; data_in = 64'h77;
      tick(); chk("fl_occ", 64'(occupancy), 64'd0); chk("fl_vld", 64'(out_valid), 64'd0);
      chk("fl_rdy", 64'(in_ready), 64'd1); chk("fl_stall", 64'(stall_cnt), 64'd5);
      flush = 0; in_valid = 0; out_ready = 1;
      tick(); chk("fl_post_vld", 64'(out_valid), 64'd0); chk("fl_post_data", data_out, 64'hB1);

      // saturation with CNT_W=3, clear override, async reset mid-stall
      clr_stats = 1;
      tick(); chk("clr_stall3", 64'(stall_cnt3), 64'd0);
      clr_stats = 0; out_ready = 0; in_valid = 1; data_in = 64'hC1;
      tick(); in_valid = 0;
      for (int i = 0; i < 10; i++) tick();
      chk("sat_stall3", 64'(stall_cnt3), 64'd7);
      chk("sat_stall16", 64'(stall_cnt), 64'd10);
      clr_stats = 1;
      tick(); chk("clr_ovr3", 64'(stall_cnt3), 64'd0);
      clr_stats = 0;
      tick(); chk("recount3", 64'(stall_cnt3), 64'd1);
      in_valid = 1; data_in = 64'hC2;
      tick(); in_valid = 0;
      chk("pre_rst_occ", 64'(occupancy), 64'd2); chk("pre_rst_stall3", 64'(stall_cnt3), 64'd2);
      #2 rst = 1'b0;
      #1;
      chk("arst_vld",   64'(out_valid), 64'd0);
      chk("arst_occ",   64'(occupancy), 64'd0);
      chk("arst_rdy",   64'(in_ready),  64'd1);
      chk("arst_data",  data_out,       64'h8000_0000);
      chk("arst_stall", 64'(stall_cnt), 64'd0);
      chk("arst_stall3", 64'(stall_cnt3), 64'd0);
      chk("arst_data3", data_out3, 64'h0);
      tick();
      rst = 1'b1;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
- Parametrised successor to the fixed-field stage registers between pipeline stages.
- Carries one packed payload bus of DATA_W bits through a valid/ready handshake, with a two-entry skid buffer so upstream ready is fully registered.
- Adds a per-beat kill (bubble insertion), a whole-stage flush, an occupancy output and a saturating stall counter.
- One instance sits between each pair of stages (IF/ID ... MEM/WB); the stage packs its fields into data_in.

Parameters:
- DATA_W, 64: payload width in bits, >=1.
- RESET_DATA, 0 (DATA_W bits): value of data_out after reset. Instances carrying a pc field set that slice to 64'h0000_0000_8000_0000 and control slices to their NOP encodings.
- CNT_W, 16: width of the stall counter, >=1.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset; state is in reset while rst==0.
- in_valid  input  1  upstream beat present.
- in_kill  input  1  qualifies in_valid; the accepted beat is dropped (bubble).
- in_ready  output  1  stage can accept a beat this cycle.
- data_in  input  DATA_W  upstream payload.
- out_valid  output  1  data_out holds a live beat.
- out_ready  input  1  downstream accepts this cycle.
- data_out  output  DATA_W  payload of the head entry.
- flush  input  1  discard all held beats (branch or trap redirect).
- clr_stats  input  1  synchronous clear of stall_cnt.
- occupancy  output  2  number of live entries, 0..2.
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- State:
  - main entry (main_v, main_d), which drives out_valid and data_out directly.
  - skid entry (skid_v, skid_d).
  - stall counter.
- Reset (rst==0, asynchronous): main_v=0, skid_v=0, main_d=RESET_DATA, skid_d=0, stall_cnt=0. All outputs take these values immediately. A reset in the middle of a transfer drops all held beats.
- in_ready = !skid_v, taken from a register only. It does not depend on out_ready, flush or in_valid in the same cycle.
- acc = in_valid & in_ready. keep = acc & !in_kill. pop = main_v & out_ready.
- Priority on each rising edge, highest first:
  1. flush=1: main_v<=0, skid_v<=0. A beat accepted in the same cycle is discarded. Payload registers hold their values.
  2. skid_v=1 and pop=1: main_d<=skid_d, main_v<=1, skid_v<=0. acc is 0 in this case because in_ready=0.
  3. keep=1 and (main_v=0 or pop=1): main_d<=data_in, main_v<=1.
  4. keep=1 and main_v=1 and pop=0: skid_d<=data_in, skid_v<=1.
  5. pop=1 and keep=0: main_v<=0.
  6. Otherwise hold.
- Beat order is strictly FIFO. Throughput is one beat per cycle when out_ready=1. Latency from data_in to data_out is 1 cycle when the stage is empty.
- Killed beats (acc=1, in_kill=1) complete the upstream handshake but are never stored and never appear downstream. This is equivalent to valid_out=0 for that beat. With in_kill=1 and in_valid=0, nothing happens.
- Full (occupancy=2): in_ready=0 and upstream must hold its beat. The stage leaves full on the first pop.
- Empty: out_valid=0. data_out holds the last value and downstream must ignore it.
- occupancy = main_v + skid_v, registered.
- stall_cnt:
  - Increments when out_valid=1 and out_ready=0.
  - Holds at 2^CNT_W-1 once it reaches it.
  - clr_stats=1 sets it to 0, which overrides an increment in the same cycle.
  - Flush does not affect it.
- Invariants (for assertions): skid_v=1 implies main_v=1. A beat never appears twice and is never lost, except by kill, flush or reset.

Test Plan:
- Reset with RESET_DATA=64'h8000_0000, then release rst -> out_valid=0, in_ready=1, occupancy=0, data_out=64'h8000_0000, stall_cnt=0.
- Stream 0x11, 0x22, 0x33 on consecutive cycles with out_ready=1 -> same values on data_out one cycle later, back to back, and occupancy stays 1.
- With out_ready=0, send 0xA1 then 0xA2 -> occupancy=2 and in_ready=0. A third beat 0xA3 held upstream is not taken. Raise out_ready -> data_out shows 0xA1, 0xA2, 0xA3 in order, and stall_cnt equals the number of stalled cycles.
- Send 0x55 with in_kill=1, then 0x66 with in_kill=0 -> in_ready=1 on both beats, and only 0x66 ever appears with out_valid=1.
- With occupancy=2, assert flush while in_valid=1 and data_in=0x77 -> next cycle occupancy=0, out_valid=0, in_ready=1, and 0x77 never appears.
- Build CNT_W=3 and hold a stall for 10 cycles -> stall_cnt stops at 7. Assert clr_stats while still stalled -> stall_cnt=0 the next cycle and counts from 1 again after that. Pull rst low in the middle of the stall -> all state clears asynchronously.
